// File: rtl/sin_channel_scheduler_if.sv
// Bundle of sequencer control, config, sine-unit and sample-output signals.
// master = environment (drives control/config/sin_y/out_ready), slave = scheduler.
interface sin_channel_scheduler_if #(
  parameter int NCH   = 4,
  parameter int ACC_W = 16
);
  localparam int CH_W = $clog2(NCH);

  logic             enable;
  logic             sync_clr;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [9:0]       sin_x;
  logic [7:0]       sin_y;
  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [7:0]       out_sample;

  modport master (
    output enable, sync_clr, cfg_we, cfg_ch, cfg_inc, sin_y, out_ready,
    input  sin_x, out_valid, out_ch, out_sample
  );

  modport slave (
    input  enable, sync_clr, cfg_we, cfg_ch, cfg_inc, sin_y, out_ready,
    output sin_x, out_valid, out_ch, out_sample
  );
endinterface

// File: rtl/sin_channel_scheduler.sv
// Round-robin DDS sequencer sharing one combinational sine lookup across NCH accumulators.
// Two cycles per sample (LOOKUP, PRESENT); a stalled sample holds until accepted.
module sin_channel_scheduler #(
  parameter int NCH   = 4,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  sin_channel_scheduler_if.slave  bus
);
  localparam int CH_W = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ch_ptr_q, ch_ptr_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_sample_q, out_sample_d;
  logic [ACC_W-1:0] acc_q [NCH];
  logic [ACC_W-1:0] acc_d [NCH];
  logic [ACC_W-1:0] inc_q [NCH];
  logic [ACC_W-1:0] inc_d [NCH];
  logic             hs;
  logic [CH_W-1:0]  ch_nxt;

  assign hs     = (state_q == S_PRESENT) && bus.out_ready;
  assign ch_nxt = (ch_ptr_q == CH_W'(NCH - 1)) ? '0 : ch_ptr_q + 1'b1;

  // Phase of the current channel is always driven; only the LOOKUP-cycle value is consumed.
  assign bus.sin_x      = acc_q[ch_ptr_q][ACC_W-1 -: 10];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_sample = out_sample_q;

  always_comb begin
    state_d      = state_q;
    ch_ptr_d     = ch_ptr_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    for (int i = 0; i < NCH; i++) begin
      acc_d[i] = acc_q[i];
      inc_d[i] = inc_q[i];
    end

    case (state_q)
      S_IDLE: begin
        out_valid_d = 1'b0;
        if (bus.enable) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        out_sample_d = bus.sin_y;
        out_ch_d     = ch_ptr_q;
        out_valid_d  = 1'b1;
        state_d      = S_PRESENT;
      end
      S_PRESENT: begin
        if (hs) begin
          acc_d[ch_ptr_q] = acc_q[ch_ptr_q] + inc_q[ch_ptr_q];
          ch_ptr_d        = ch_nxt;
          out_valid_d     = 1'b0;
          state_d         = bus.enable ? S_LOOKUP : S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Accumulation above reads inc_q, so a same-cycle write only affects later handshakes.
    if (bus.cfg_we && (int'(bus.cfg_ch) < NCH)) inc_d[bus.cfg_ch] = bus.cfg_inc;

    if (bus.sync_clr) begin
      for (int i = 0; i < NCH; i++) acc_d[i] = '0;
      ch_ptr_d    = '0;
      out_valid_d = 1'b0;
      state_d     = bus.enable ? S_LOOKUP : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_ptr_q     <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ch_ptr_q     <= ch_ptr_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end
endmodule
